if_fetch: RTL and testbench

- Instruction-fetch unit feeding the decode stage of the RISC-V pipeline.
- Owns the PC and assembles each 32-bit little-endian instruction from a byte-wide, one-cycle-latency memory port, shared with the memory stage through an arbiter.
- Hands instructions to the IF/ID register.
- Consumes decode's redirect (jump_i/jump_addr_i) and squashes in-flight work on a redirect.

---
 rtl/if_fetch.sv | 101 ++++++++++
 tb/tb_if_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit little-endian instructions from a byte-wide,
// one-cycle-latency shared memory port and hands them to the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        busy_o
);

  logic [31:0] pc, pc_eff, pc_next;
  logic [2:0]  k, k_eff, k_next;
  logic        pend_v, pend_v_next;
  logic [1:0]  pend_idx;
  logic [7:0]  b0, b1, b2;
  logic        buf_v, buf_v_next;
  logic [31:0] buf_inst, buf_pc;
  logic [31:0] assembled;
  logic        complete, issue, drain, deliver, park;

  // When byte 3 lands this cycle the next fetch's byte 0 is requested in the same
  // cycle, so the request side looks ahead to the post-completion pc/k.
  always_comb begin
    complete  = pend_v & (pend_idx == 2'd3);
    pc_eff    = complete ? pc + 32'd4 : pc;
    k_eff     = complete ? 3'd0 : k;
    assembled = {mem_din_i, b2, b1, b0};
    drain     = buf_v & ~stall_i & ~jump_i;
    deliver   = complete & ~stall_i & ~jump_i;
    park      = complete & stall_i & ~jump_i;
    mem_rd_o  = rst & ~jump_i & (k_eff < 3'd4) & (~(buf_v | complete) | ~stall_i);
    mem_a_o   = pc_eff + {29'd0, k_eff};
    issue     = mem_rd_o & mem_grant_i;

    pc_next     = pc_eff;
    k_next      = issue ? k_eff + 3'd1 : k_eff;
    pend_v_next = issue;
    buf_v_next  = park | (buf_v & ~drain);
    if (jump_i) begin
      pc_next     = jump_addr_i;
      k_next      = 3'd0;
      pend_v_next = 1'b0;
      buf_v_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      k            <= 3'd0;
      pend_v       <= 1'b0;
      buf_v        <= 1'b0;
      busy_o       <= 1'b0;
      inst_valid_o <= 1'b0;
      pc_o         <= 32'd0;
      inst_o       <= 32'd0;
    end else begin
      pc           <= pc_next;
      k            <= k_next;
      pend_v       <= pend_v_next;
      buf_v        <= buf_v_next;
      busy_o       <= (k_next != 3'd0) | pend_v_next | buf_v_next;
      inst_valid_o <= drain | deliver;
      if (drain) begin
        inst_o <= buf_inst;
        pc_o   <= buf_pc;
      end else if (deliver) begin
        inst_o <= assembled;
        pc_o   <= pc + 32'd4;
      end
    end
  end

  // Byte and buffer storage is qualified by pend_v/buf_v, so it needs no reset.
  always_ff @(posedge clk) begin
    if (issue) pend_idx <= k_eff[1:0];
    if (pend_v && !jump_i) begin
      case (pend_idx)
        2'd0:    b0 <= mem_din_i;
        2'd1:    b1 <= mem_din_i;
        2'd2:    b2 <= mem_din_i;
        default: ;
      endcase
    end
    if (park) begin
      buf_inst <= assembled;
      buf_pc   <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte-wide one-cycle-latency memory model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, jump_i, mem_grant_i;
  logic [31:0] jump_addr_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o, pc_o, inst_o;
  logic        mem_rd_o, inst_valid_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
    .mem_a_o(mem_a_o), .mem_rd_o(mem_rd_o), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .busy_o(busy_o)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h93;
      32'd1:   return 8'h00;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  // Memory responds one cycle after a granted read
  always @(posedge clk)
    if (mem_rd_o && mem_grant_i) mem_din_i <= mem_byte(mem_a_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic g, input logic s, input logic j, input logic [31:0] ja);
    mem_grant_i = g;
    stall_i     = s;
    jump_i      = j;
    jump_addr_i = ja;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    mem_grant_i = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_din_i = 8'h00;

    // 1: best-case fetch
    do_reset;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      if (c == 0) begin
        check("t1 reset pc_o", pc_o, 32'd0);
        check("t1 reset inst_o", inst_o, 32'd0);
        check("t1 reset valid", {31'd0, inst_valid_o}, 32'd0);
        check("t1 reset busy", {31'd0, busy_o}, 32'd0);
      end
      if (c < 5) begin
        check($sformatf("t1 rd c%0d", c), {31'd0, mem_rd_o}, 32'd1);
        check($sformatf("t1 addr c%0d", c), mem_a_o, 32'(c));
      end
      if (c == 4) check("t1 valid c4", {31'd0, inst_valid_o}, 32'd0);
      if (c == 5) begin
        check("t1 valid c5", {31'd0, inst_valid_o}, 32'd1);
        check("t1 inst", inst_o, 32'h0010_0093);
        check("t1 pc_o", pc_o, 32'h4);
      end
      if (c == 6) check("t1 valid c6", {31'd0, inst_valid_o}, 32'd0);
      next_cycle;
    end

    // 2: grant withheld in cycle 2
    do_reset;
    for (int c = 0; c < 7; c++) begin
      logic [31:0] exp_a [6];
      exp_a = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd3, 32'd4};
      drive(c != 2, 1'b0, 1'b0, 32'd0);
      if (c < 6) check($sformatf("t2 addr c%0d", c), mem_a_o, exp_a[c]);
      if (c == 5) check("t2 valid c5", {31'd0, inst_valid_o}, 32'd0);
      if (c == 6) begin
        check("t2 valid c6", {31'd0, inst_valid_o}, 32'd1);
        check("t2 inst", inst_o, 32'h0010_0093);
      end
      next_cycle;
    end

    // 3: stall cycles 3..9 buffers the instruction
    do_reset;
    vcount = 0;
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, (c >= 3 && c <= 9), 1'b0, 32'd0);
      if (inst_valid_o) vcount++;
      if (c >= 4 && c <= 9) check($sformatf("t3 rd off c%0d", c), {31'd0, mem_rd_o}, 32'd0);
      if (c == 6) check("t3 busy", {31'd0, busy_o}, 32'd1);
      if (c == 10) begin
        check("t3 rd resume", {31'd0, mem_rd_o}, 32'd1);
        check("t3 addr resume", mem_a_o, 32'h4);
      end
      if (c == 11) begin
        check("t3 valid", {31'd0, inst_valid_o}, 32'd1);
        check("t3 inst", inst_o, 32'h0010_0093);
        check("t3 pc_o", pc_o, 32'h4);
      end
      next_cycle;
    end
    check("t3 pulse count", 32'(vcount), 32'd1);

    // 4: redirect mid-fetch
    do_reset;
    vcount = 0;
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 1'b0, (c == 2), 32'h100);
      if (c < 8 && inst_valid_o) vcount++;
      if (c == 2) check("t4 rd on jump", {31'd0, mem_rd_o}, 32'd0);
      if (c == 3) check("t4 addr target", mem_a_o, 32'h100);
      if (c == 8) begin
        check("t4 valid", {31'd0, inst_valid_o}, 32'd1);
        check("t4 pc_o", pc_o, 32'h104);
        check("t4 inst", inst_o, 32'hA7A6_A5A4);
      end
      next_cycle;
    end
    check("t4 squashed pulses", 32'(vcount), 32'd0);

    // 5a: redirect on the completion edge, target wraps past 0xFFFFFFFF
    do_reset;
    vcount = 0;
    for (int c = 0; c < 11; c++) begin
      drive(1'b1, 1'b0, (c == 4), 32'hFFFF_FFFC);
      if (c < 10 && inst_valid_o) vcount++;
      if (c == 5) check("t5a addr target", mem_a_o, 32'hFFFF_FFFC);
      if (c == 9) check("t5a addr wrap", mem_a_o, 32'h0);
      if (c == 10) begin
        check("t5a valid", {31'd0, inst_valid_o}, 32'd1);
        check("t5a inst", inst_o, 32'hA5A4_A7A6);
        check("t5a pc_o", pc_o, 32'h0);
      end
      next_cycle;
    end
    check("t5a dropped pulses", 32'(vcount), 32'd0);

    // 5b: redirect while an instruction is buffered under stall
    do_reset;
    vcount = 0;
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, (c >= 3 && c <= 7), (c == 6), 32'h100);
      if (c < 12 && inst_valid_o) vcount++;
      if (c == 5) check("t5b busy buffered", {31'd0, busy_o}, 32'd1);
      if (c == 7) begin
        check("t5b busy cleared", {31'd0, busy_o}, 32'd0);
        check("t5b rd restart", {31'd0, mem_rd_o}, 32'd1);
        check("t5b addr restart", mem_a_o, 32'h100);
      end
      if (c == 12) begin
        check("t5b valid", {31'd0, inst_valid_o}, 32'd1);
        check("t5b pc_o", pc_o, 32'h104);
      end
      next_cycle;
    end
    check("t5b dropped pulses", 32'(vcount), 32'd0);

    // 6: asynchronous reset during byte 2 of the second fetch
    do_reset;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      if (c == 6) begin
        check("t6 pc_o before", pc_o, 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("t6 pc_o", pc_o, 32'd0);
        check("t6 inst_o", inst_o, 32'd0);
        check("t6 valid", {31'd0, inst_valid_o}, 32'd0);
        check("t6 busy", {31'd0, busy_o}, 32'd0);
        check("t6 rd", {31'd0, mem_rd_o}, 32'd0);
      end else begin
        next_cycle;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      if (c == 0) begin
        check("t6 first rd", {31'd0, mem_rd_o}, 32'd1);
        check("t6 first addr", mem_a_o, 32'h0);
      end
      if (c == 5) begin
        check("t6 valid", {31'd0, inst_valid_o}, 32'd1);
        check("t6 inst after", inst_o, 32'h0010_0093);
      end
      next_cycle;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
